// File: rtl/maxnet_loader.sv
// Frame loader and sequencer for the Maxnet core: collects eps,a1..a4, starts the core, waits with timeout, holds the result.
// Optional build macro: LOADER_FPCHECK_EN enables the IEEE-754 frame sanity check in CHECK.
module maxnet_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] eps,
    output logic [31:0] a1,
    output logic [31:0] a2,
    output logic [31:0] a3,
    output logic [31:0] a4,
    output logic        mx_start,
    input  logic        mx_finish,
    input  logic        mx_overflow,
    input  logic [31:0] mx_out,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_overflow,
    output logic        res_timeout,
    input  logic        res_ack,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CHECK = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [15:0] tmo_reg, tmo_next;
    logic [31:0] words_reg [0:4];
    logic        ready_en_reg;
    logic [31:0] res_data_reg;
    logic        res_overflow_reg;
    logic        res_timeout_reg;
    logic        accept;
    logic        check_fail;
    logic        cap_finish;
    logic        cap_timeout;

    // in_ready is held low for one cycle after reset releases
    assign in_ready = (state_reg == LOAD) && ready_en_reg;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_reg != LOAD);
    assign mx_start = (state_reg == START);
    assign res_valid = (state_reg == HOLD);

    assign eps = words_reg[0];
    assign a1  = words_reg[1];
    assign a2  = words_reg[2];
    assign a3  = words_reg[3];
    assign a4  = words_reg[4];

    assign res_data     = res_data_reg;
    assign res_overflow = res_overflow_reg;
    assign res_timeout  = res_timeout_reg;

`ifdef LOADER_FPCHECK_EN
    logic [4:0] word_bad;

    // eps must be negative, a1..a4 non-negative, and no word may be Inf/NaN
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_fpchk
            if (gi == 0) begin : g_eps
                assign word_bad[gi] = (words_reg[gi][30:23] == 8'hFF) || !words_reg[gi][31];
            end else begin : g_a
                assign word_bad[gi] = (words_reg[gi][30:23] == 8'hFF) || words_reg[gi][31];
            end
        end
    endgenerate

    assign check_fail = |word_bad;
    assign frame_err  = (state_reg == CHECK) && check_fail;
`else
    assign check_fail = 1'b0;
    assign frame_err  = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_words
            always_ff @(posedge clk) begin
                if (rst) begin
                    words_reg[gi] <= '0;
                end else if (accept && (cnt_reg == 3'(gi))) begin
                    words_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tmo_next    = tmo_reg;
        cap_finish  = 1'b0;
        cap_timeout = 1'b0;
        case (state_reg)
            LOAD: begin
                if (accept) begin
                    if (cnt_reg == 3'd4) begin
                        cnt_next   = 3'd0;
                        state_next = CHECK;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            CHECK: begin
                state_next = check_fail ? LOAD : START;
            end
            START: begin
                tmo_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // a finish arriving on the last allowed cycle beats the timeout
                if (mx_finish) begin
                    cap_finish = 1'b1;
                    state_next = HOLD;
                end else if (tmo_reg == TMO_LAST) begin
                    cap_timeout = 1'b1;
                    state_next  = HOLD;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            HOLD: begin
                if (res_ack) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= LOAD;
            cnt_reg          <= 3'd0;
            tmo_reg          <= '0;
            ready_en_reg     <= 1'b0;
            res_data_reg     <= '0;
            res_overflow_reg <= 1'b0;
            res_timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            ready_en_reg <= 1'b1;
            if (cap_finish) begin
                res_data_reg     <= mx_out;
                res_overflow_reg <= mx_overflow;
                res_timeout_reg  <= 1'b0;
            end else if (cap_timeout) begin
                res_data_reg     <= '0;
                res_overflow_reg <= 1'b0;
                res_timeout_reg  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed bench for maxnet_loader: the bench plays upstream source, Maxnet core and result consumer.
module tb_maxnet_loader;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] eps, a1, a2, a3, a4;
    logic        mx_start;
    logic        mx_finish;
    logic        mx_overflow;
    logic [31:0] mx_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_overflow;
    logic        res_timeout;
    logic        res_ack;
    logic        busy;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        tmo;
    } res_t;
    res_t sb[$];

    logic [31:0] frame_a [0:4] = '{32'hBE4CCCCD, 32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD};
    logic [31:0] frame_n [0:4] = '{32'hBE4CCCCD, 32'h3E4CCCCD, 32'h7FC00000, 32'h3F19999A, 32'h3F4CCCCD};
    logic [31:0] frame_b [0:4] = '{32'hBF000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    always #5 clk = ~clk;

    maxnet_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .eps(eps), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .mx_start(mx_start), .mx_finish(mx_finish), .mx_overflow(mx_overflow), .mx_out(mx_out),
        .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
        .res_timeout(res_timeout), .res_ack(res_ack),
        .busy(busy), .frame_err(frame_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one frame; returns with the last word just accepted (DUT in CHECK).
    task automatic send_frame(input logic [31:0] w [0:4], input int gap);
        int n;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            for (int g = 0; g < gap; g++) step();
            in_valid = 1'b1;
            in_data  = w[i];
            n = 0;
            while (!in_ready && n < 50) begin
                step();
                n++;
            end
            check("in_ready_wait", {31'b0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_operands(input string tag, input logic [31:0] w [0:4]);
        check({tag, "_eps"}, eps, w[0]);
        check({tag, "_a1"}, a1, w[1]);
        check({tag, "_a2"}, a2, w[2]);
        check({tag, "_a3"}, a3, w[3]);
        check({tag, "_a4"}, a4, w[4]);
    endtask

    // Called in CHECK; leaves the DUT in START.
    task automatic expect_start(input string tag);
        check({tag, "_chk_start"}, {31'b0, mx_start}, 32'd0);
        check({tag, "_chk_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_chk_ready"}, {31'b0, in_ready}, 32'd0);
        step();
        check({tag, "_start"}, {31'b0, mx_start}, 32'd1);
    endtask

    // Called in START; core finishes on the d-th WAIT cycle.
    task automatic core_respond(input int d, input logic [31:0] val, input logic ovf);
        res_t e;
        e.data = val; e.ovf = ovf; e.tmo = 1'b0;
        sb.push_back(e);
        mx_finish = 1'b0;
        for (int i = 0; i < d; i++) step();
        mx_finish   = 1'b1;
        mx_out      = val;
        mx_overflow = ovf;
        step();
        mx_finish   = 1'b0;
        mx_overflow = 1'b0;
        mx_out      = $urandom;
    endtask

    task automatic pop_check(input string tag);
        res_t e;
        check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_res_data"}, res_data, e.data);
            check({tag, "_res_ovf"}, {31'b0, res_overflow}, {31'b0, e.ovf});
            check({tag, "_res_tmo"}, {31'b0, res_timeout}, {31'b0, e.tmo});
        end
    endtask

    task automatic do_ack(input string tag);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        check({tag, "_ack_valid"}, {31'b0, res_valid}, 32'd0);
        check({tag, "_ack_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_ack_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        res_t e;
        logic [31:0] held;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mx_finish = 1'b0;
        mx_overflow = 1'b0; mx_out = '0; res_ack = 1'b0;
        step(); step();
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, res_valid}, 32'd0);
        check("rst_start", {31'b0, mx_start}, 32'd0);
        check("rst_eps", eps, 32'd0);
        check("rst_ferr", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        check("rel_ready0", {31'b0, in_ready}, 32'd0);
        step();
        check("rel_ready1", {31'b0, in_ready}, 32'd1);

        // continuous frame, nominal result
        send_frame(frame_a, 0);
        check_operands("f1", frame_a);
        expect_start("f1");
        core_respond(2, 32'h3F4CCCCD, 1'b0);
        pop_check("f1");
        do_ack("f1");

        // gapped frame with garbage on in_data while invalid
        send_frame(frame_a, 2);
        check_operands("f2", frame_a);
        expect_start("f2");
        core_respond(1, 32'h3F4CCCCD, 1'b0);
        pop_check("f2");
        do_ack("f2");

        // NaN in a2
        send_frame(frame_n, 0);
`ifdef LOADER_FPCHECK_EN
        check("nan_ferr", {31'b0, frame_err}, 32'd1);
        step();
        check("nan_ferr_off", {31'b0, frame_err}, 32'd0);
        check("nan_no_start", {31'b0, mx_start}, 32'd0);
        check("nan_ready", {31'b0, in_ready}, 32'd1);
`else
        check("nan_ferr", {31'b0, frame_err}, 32'd0);
        expect_start("nan");
        core_respond(1, 32'h12345678, 1'b1);
        pop_check("nan");
        do_ack("nan");
`endif

        // timeout, then a normal frame
        send_frame(frame_b, 0);
        expect_start("tmo");
        e.data = '0; e.ovf = 1'b0; e.tmo = 1'b1;
        sb.push_back(e);
        n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        check("tmo_latency_ok", {31'b0, (n >= T + 1) && (n <= T + 2)}, 32'd1);
        pop_check("tmo");
        do_ack("tmo");
        send_frame(frame_a, 1);
        expect_start("post_tmo");
        core_respond(3, 32'h3F4CCCCD, 1'b0);
        pop_check("post_tmo");
        do_ack("post_tmo");

        // finish on the final allowed WAIT cycle wins over timeout
        send_frame(frame_b, 0);
        expect_start("edge");
        core_respond(T, 32'h40A00000, 1'b1);
        pop_check("edge");

        // ack withheld; in_valid during HOLD must not load anything
        held = res_data;
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, res_valid}, 32'd1);
            check("hold_data", res_data, held);
            check("hold_ready", {31'b0, in_ready}, 32'd0);
            check("hold_eps", eps, frame_b[0]);
            step();
        end
        in_valid = 1'b0;
        do_ack("hold");

        // reset during WAIT, late finish ignored
        send_frame(frame_a, 0);
        expect_start("rstw");
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw_busy", {31'b0, busy}, 32'd0);
        check("rstw_valid", {31'b0, res_valid}, 32'd0);
        check("rstw_ready", {31'b0, in_ready}, 32'd0);
        check("rstw_a4", a4, 32'd0);
        mx_finish = 1'b1;
        mx_out    = 32'h3F800000;
        step();
        mx_finish = 1'b0;
        check("late_valid", {31'b0, res_valid}, 32'd0);
        check("late_busy", {31'b0, busy}, 32'd0);
        check("late_data", res_data, 32'd0);
        check("late_ready", {31'b0, in_ready}, 32'd1);

        // normal frame after the abort
        send_frame(frame_b, 0);
        check_operands("f_last", frame_b);
        expect_start("f_last");
        core_respond(4, 32'h3E800000, 1'b0);
        pop_check("f_last");
        do_ack("f_last");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxnet_loader.md
MAXNET_LOADER -- requirements
Module: maxnet_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: max cycles to wait for mx_finish after mx_start; range 1..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream word valid.
REQ-005 SHALL have port in_data, input, 32, IEEE-754 single word; frame order is eps, a1, a2, a3, a4.
REQ-006 SHALL have port in_ready, output, 1, loader can accept a word.
REQ-007 SHALL have ports eps, a1, a2, a3, a4, output, 32 each, operands to the Maxnet core.
REQ-008 SHALL have port mx_start, output, 1, one-cycle start pulse to the core.
REQ-009 SHALL have ports mx_finish (1), mx_overflow (1), mx_out (32), inputs, core status and result.
REQ-010 SHALL have ports res_valid (1), res_data (32), res_overflow (1), res_timeout (1), outputs, captured result.
REQ-011 SHALL have port res_ack, input, 1, downstream consumes the result.
REQ-012 SHALL have ports busy (1) and frame_err (1), outputs.

Function
REQ-013 SHALL implement states LOAD, CHECK, START, WAIT and HOLD.
REQ-014 In LOAD: in_ready=1; a word is accepted when in_valid&&in_ready; 3-bit word counter 0..4 selects eps/a1..a4; accepting word 4 moves to CHECK, counter returns to 0.
REQ-015 CHECK SHALL last exactly one cycle: pass -> START; fail -> frame_err=1 for that one cycle, then LOAD with the frame discarded.
REQ-016 START SHALL drive mx_start=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-017 WAIT SHALL sample mx_finish from the first cycle after the pulse; on mx_finish=1, capture mx_out to res_data and mx_overflow to res_overflow, set res_timeout=0, and go to HOLD.
REQ-018 In WAIT, when the counter reaches TIMEOUT_CYCLES without mx_finish: res_data=0, res_overflow=0, res_timeout=1, go to HOLD; mx_finish in that same cycle SHALL win over timeout.
REQ-019 HOLD: res_valid=1 with res_* stable until the cycle res_ack=1, then LOAD next cycle; res_ack outside HOLD is ignored.
REQ-020 eps/a1..a4 SHALL change only on an accepted word and remain stable from CHECK through HOLD.
REQ-021 busy=1 in CHECK, START, WAIT and HOLD; 0 in LOAD.
REQ-022 in_ready=0 in all states but LOAD; in_valid there SHALL have no effect.
REQ-023 Latency: last-word acceptance to mx_start = 2 cycles; mx_finish sampled to res_valid = 1 cycle.

Reset
REQ-024 rst=1 SHALL, at the next edge, force LOAD, counter 0, and all outputs 0 (in_ready becomes 1 the cycle after rst falls), aborting any frame or wait mid-operation.
REQ-025 rst SHALL take precedence over every simultaneous event.

Configuration
REQ-026 With LOADER_FPCHECK_EN defined, CHECK SHALL fail if any word has exponent 0xFF, if eps sign=0, or if any a1..a4 sign=1.
REQ-027 Without LOADER_FPCHECK_EN, CHECK SHALL always pass and frame_err SHALL be tied to 0.

Verification
REQ-028 Reset, then frame BE4CCCCD, 3E4CCCCD, 3ECCCCCD, 3F19999A, 3F4CCCCD with in_valid continuous -> operands latched in order, mx_start pulses 2 cycles after the last word; core finish with mx_out=3F4CCCCD -> res_valid=1, res_data=3F4CCCCD, res_overflow=0.
REQ-029 Gaps in in_valid between words -> only valid words counted; result identical to REQ-028.
REQ-030 With LOADER_FPCHECK_EN, a2=7FC00000 -> frame_err pulses 1 cycle, no mx_start, in_ready=1 next cycle; without the macro -> mx_start issued.
REQ-031 TIMEOUT_CYCLES=8, mx_finish held 0 -> res_valid with res_timeout=1, res_data=0; a subsequent frame completes normally.
REQ-032 rst asserted during WAIT, then a late mx_finish -> ignored, outputs 0, busy=0.
REQ-033 res_ack withheld 5 cycles -> res_* stable and in_ready=0 throughout; ack -> LOAD next cycle.
